// File: rtl/array44_seq_ctrl.sv
// array44_seq_ctrl
// Job sequencer for the 4x4 systolic top. Each accepted start streams
// FEED_LEN words from the input SRAM into the array, lets the array drain,
// then writes OUT_LEN accout words into the output SRAM.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; bases captured when start is accepted
//   S_FEED  | input SRAM read k = 0..FEED_LEN-1, one word per cycle
//   S_DRAIN | last array input-valid cycle plus DRAIN_CYC quiet cycles
//   S_WB    | output_en_sys for OUT_LEN cycles, writes lag by OUT_LAT
//   S_FIN   | done pulse, busy still high
//
// Every output is a flop. The output decode looks at the *next* state and
// counter so that each flop shows the phase the FSM is entering.
module array44_seq_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int FEED_LEN  = 7,
    parameter int DRAIN_CYC = 4,
    parameter int OUT_LEN   = 4,
    parameter int OUT_LAT   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] in_base_i,
    input  logic [ADDR_W-1:0] out_base_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              input_en_ramin_o,
    output logic              wr_in_o,
    output logic [ADDR_W-1:0] adder_in_o,
    output logic              input_en_sys_o,
    output logic              output_en_sys_o,
    output logic              input_en_ramout_o,
    output logic              wr_out_o,
    output logic [ADDR_W-1:0] adder_out_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_DRAIN = 3'd2,
        S_WB    = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    // The write-back phase covers the output_en_sys window plus the write lag.
    localparam int WB_LEN  = OUT_LEN + OUT_LAT;
    localparam int MAX_A   = (FEED_LEN > WB_LEN) ? FEED_LEN : WB_LEN;
    localparam int MAX_CNT = (MAX_A > DRAIN_CYC + 1) ? MAX_A : DRAIN_CYC + 1;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] WB_LAST    = CNT_W'(WB_LEN - 1);
    localparam logic [CNT_W-1:0] OEN_END    = CNT_W'(OUT_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W:0]   LAT_X      = (CNT_W + 1)'(OUT_LAT);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   in_base_q, in_base_d;
    logic [ADDR_W-1:0]   out_base_q, out_base_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ramin_q, ramin_d;
    logic                wr_in_q;
    logic [ADDR_W-1:0]   adder_in_q, adder_in_d;
    logic                sys_q, sys_d;
    logic                oen_q, oen_d;
    logic                ramout_q, ramout_d;
    logic                wr_out_q, wr_out_d;
    logic [ADDR_W-1:0]   adder_out_q, adder_out_d;

    logic [CNT_W:0]      wr_idx;

    // State register: phase, phase counter and the captured base addresses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
        end
    end

    // Next-state logic: each phase runs its counter up to its last index.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_FEED;
                    cnt_d      = '0;
                    in_base_d  = in_base_i;
                    out_base_d = out_base_i;
                end
            end
            S_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DRAIN: begin
                // Count 0 is the trailing input_en_sys cycle, then DRAIN_CYC idle cycles.
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_WB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WB: begin
                if (cnt_q == WB_LAST) begin
                    state_d = S_FIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming phase; writes trail output_en_sys by OUT_LAT.
    always_comb begin
        wr_idx      = {1'b0, cnt_d} - LAT_X;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
        ramin_d     = (state_d == S_FEED);
        adder_in_d  = '0;
        if (ramin_d) begin
            adder_in_d = in_base_d + ADDR_W'(cnt_d);
        end
        sys_d       = ramin_q;
        oen_d       = (state_d == S_WB) && (cnt_d < OEN_END);
        wr_out_d    = (state_d == S_WB) && !wr_idx[CNT_W];
        ramout_d    = wr_out_d;
        adder_out_d = '0;
        if (wr_out_d) begin
            adder_out_d = out_base_d + ADDR_W'(wr_idx[CNT_W-1:0]);
        end
    end

    // Output registers; reset drops every strobe, including in-flight writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ramin_q     <= 1'b0;
            wr_in_q     <= 1'b0;
            adder_in_q  <= '0;
            sys_q       <= 1'b0;
            oen_q       <= 1'b0;
            ramout_q    <= 1'b0;
            wr_out_q    <= 1'b0;
            adder_out_q <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            ramin_q     <= ramin_d;
            wr_in_q     <= 1'b0;
            adder_in_q  <= adder_in_d;
            sys_q       <= sys_d;
            oen_q       <= oen_d;
            ramout_q    <= ramout_d;
            wr_out_q    <= wr_out_d;
            adder_out_q <= adder_out_d;
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign input_en_ramin_o  = ramin_q;
    assign wr_in_o           = wr_in_q;
    assign adder_in_o        = adder_in_q;
    assign input_en_sys_o    = sys_q;
    assign output_en_sys_o   = oen_q;
    assign input_en_ramout_o = ramout_q;
    assign wr_out_o          = wr_out_q;
    assign adder_out_o       = adder_out_q;

endmodule

// File: tb/tb_array44_seq_ctrl.sv
// Bench for array44_seq_ctrl: a default-parameter instance and a minimal
// instance (FEED_LEN=1, DRAIN_CYC=0, OUT_LEN=1, OUT_LAT=0), each surrounded
// by simple SRAM/array models so the written results can be compared with
// a golden sum.
module tb_array44_seq_ctrl;

    localparam int MASK = 2047;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        ramin;
        logic        wr_in;
        logic [10:0] adder_in;
        logic        sys;
        logic        oen;
        logic        ramout;
        logic        wr_out;
        logic [10:0] adder_out;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_d, start_s, clr_d, clr_s;
    logic [10:0] in_base, out_base;

    logic        d_busy, d_done, d_ramin, d_wr_in, d_sys, d_oen, d_ramout, d_wr_out;
    logic [10:0] d_adder_in, d_adder_out;
    logic        s_busy, s_done, s_ramin, s_wr_in, s_sys, s_oen, s_ramout, s_wr_out;
    logic [10:0] s_adder_in, s_adder_out;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    array44_seq_ctrl u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_d),
        .in_base_i(in_base), .out_base_i(out_base),
        .busy_o(d_busy), .done_o(d_done),
        .input_en_ramin_o(d_ramin), .wr_in_o(d_wr_in), .adder_in_o(d_adder_in),
        .input_en_sys_o(d_sys), .output_en_sys_o(d_oen),
        .input_en_ramout_o(d_ramout), .wr_out_o(d_wr_out), .adder_out_o(d_adder_out)
    );

    array44_seq_ctrl #(.ADDR_W(11), .FEED_LEN(1), .DRAIN_CYC(0), .OUT_LEN(1), .OUT_LAT(0)) u_small (
        .clk_i(clk), .rst_i(rst), .start_i(start_s),
        .in_base_i(in_base), .out_base_i(out_base),
        .busy_o(s_busy), .done_o(s_done),
        .input_en_ramin_o(s_ramin), .wr_in_o(s_wr_in), .adder_in_o(s_adder_in),
        .input_en_sys_o(s_sys), .output_en_sys_o(s_oen),
        .input_en_ramout_o(s_ramout), .wr_out_o(s_wr_out), .adder_out_o(s_adder_out)
    );

    function automatic logic [31:0] in_word(input logic [10:0] a);
        return (32'(a) * 32'd2654435761) ^ 32'h5a5a_0000;
    endfunction

    // Environment models: input SRAM (1-cycle read), accumulating array, output SRAM.
    logic [31:0] d_rdata, d_acc, d_accout, d_j;
    logic [31:0] s_rdata, s_acc, s_j;
    logic [31:0] d_mem [0:2047];
    logic [31:0] s_mem [0:2047];

    always @(posedge clk) begin
        if (d_ramin && !d_wr_in) d_rdata <= in_word(d_adder_in);
        if (clr_d) begin
            d_acc <= 32'd0;
            d_j   <= 32'd0;
        end else begin
            if (d_sys) d_acc <= d_acc + d_rdata;
            if (d_oen) begin
                d_accout <= d_acc + d_j;
                d_j      <= d_j + 32'd1;
            end
        end
        if (d_ramout && d_wr_out) d_mem[d_adder_out] <= d_accout;
    end

    always @(posedge clk) begin
        if (s_ramin && !s_wr_in) s_rdata <= in_word(s_adder_in);
        if (clr_s) begin
            s_acc <= 32'd0;
            s_j   <= 32'd0;
        end else begin
            if (s_sys) s_acc <= s_acc + s_rdata;
            if (s_oen) s_j <= s_j + 32'd1;
        end
        if (s_ramout && s_wr_out) s_mem[s_adder_out] <= s_acc + s_j;
    end

    task automatic chk(input string tag, input int t, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s t=%0d observed=0x%0h expected=0x%0h", tag, t, o, e);
        end
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.busy = d_busy;  o.done = d_done;  o.ramin = d_ramin;  o.wr_in = d_wr_in;
            o.adder_in = d_adder_in;  o.sys = d_sys;  o.oen = d_oen;
            o.ramout = d_ramout;  o.wr_out = d_wr_out;  o.adder_out = d_adder_out;
        end else begin
            o.busy = s_busy;  o.done = s_done;  o.ramin = s_ramin;  o.wr_in = s_wr_in;
            o.adder_in = s_adder_in;  o.sys = s_sys;  o.oen = s_oen;
            o.ramout = s_ramout;  o.wr_out = s_wr_out;  o.adder_out = s_adder_out;
        end
        return o;
    endfunction

    // Reference timeline: cycle t counts from 1 = first cycle after the accepting edge.
    function automatic obs_t expect_at(input int t, input int fl, input int dc, input int ol,
                                       input int lat, input logic [10:0] ib, input logic [10:0] ob);
        obs_t e;
        int ws;
        e  = '0;
        ws = fl + 2 + dc;
        e.ramin = (t >= 1) && (t <= fl);
        if (e.ramin) e.adder_in = 11'((int'(ib) + t - 1) & MASK);
        e.sys    = (t >= 2) && (t <= fl + 1);
        e.oen    = (t >= ws) && (t < ws + ol);
        e.wr_out = (t >= ws + lat) && (t < ws + lat + ol);
        e.ramout = e.wr_out;
        if (e.wr_out) e.adder_out = 11'((int'(ob) + t - ws - lat) & MASK);
        e.done = (t == ws + lat + ol);
        e.busy = (t >= 1) && (t <= ws + lat + ol);
        return e;
    endfunction

    task automatic chk_obs(input int t, input obs_t o, input obs_t e);
        chk("busy",      t, 32'(o.busy),      32'(e.busy));
        chk("done",      t, 32'(o.done),      32'(e.done));
        chk("ramin",     t, 32'(o.ramin),     32'(e.ramin));
        chk("wr_in",     t, 32'(o.wr_in),     32'(e.wr_in));
        chk("adder_in",  t, 32'(o.adder_in),  32'(e.adder_in));
        chk("in_en_sys", t, 32'(o.sys),       32'(e.sys));
        chk("out_en_sys",t, 32'(o.oen),       32'(e.oen));
        chk("ramout",    t, 32'(o.ramout),    32'(e.ramout));
        chk("wr_out",    t, 32'(o.wr_out),    32'(e.wr_out));
        chk("adder_out", t, 32'(o.adder_out), 32'(e.adder_out));
    endtask

    // Runs one job on the selected instance; called just after a rising edge.
    task automatic run_job(input int sel, input logic [10:0] ib, input logic [10:0] ob,
                           input bit hold, input int abort_t);
        int fl, dc, ol, lat, lexp;
        int n_sys, n_wr, done_t;
        obs_t o, e;
        logic [31:0] sum, got;
        logic [10:0] a;
        n_sys = 0; n_wr = 0; done_t = -1;
        if (sel == 0) begin fl = 7; dc = 4; ol = 4; lat = 1; end
        else          begin fl = 1; dc = 0; ol = 1; lat = 0; end
        lexp = fl + 2 + dc + lat + ol;
        in_base  = ib;
        out_base = ob;
        if (sel == 0) begin start_d = 1'b1; clr_d = 1'b1; end
        else          begin start_s = 1'b1; clr_s = 1'b1; end
        @(posedge clk);
        for (int t = 1; t <= lexp + 1; t++) begin
            #1;
            if (t == 1) begin
                clr_d = 1'b0;
                clr_s = 1'b0;
                if (!hold) begin start_d = 1'b0; start_s = 1'b0; end
            end
            o = sample(sel);
            e = expect_at(t, fl, dc, ol, lat, ib, ob);
            chk_obs(t, o, e);
            if (o.sys)    n_sys++;
            if (o.wr_out) n_wr++;
            if (o.done && done_t < 0) done_t = t;
            if (t == abort_t) return;
            if (t <= lexp) @(posedge clk);
        end
        chk("n_input_en_sys", 0, n_sys, fl);
        chk("n_wr_out",       0, n_wr,  ol);
        chk("done_latency",   0, done_t, lexp);
        sum = 32'd0;
        for (int k = 0; k < fl; k++) sum = sum + in_word(11'((int'(ib) + k) & MASK));
        for (int j = 0; j < ol; j++) begin
            a   = 11'((int'(ob) + j) & MASK);
            got = (sel == 0) ? d_mem[a] : s_mem[a];
            chk("out_sram", j, got, sum + 32'(j));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk_obs(0, sample(0), '0);
            chk_obs(0, sample(1), '0);
        end
    endtask

    // Protocol monitor: wr_in never set, done never on two consecutive cycles.
    logic d_done_p = 1'b0, s_done_p = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_wr_in_d", 0, 32'(d_wr_in), 32'd0);
            chk("mon_wr_in_s", 0, 32'(s_wr_in), 32'd0);
            chk("mon_done_consec_d", 0, 32'(d_done & d_done_p), 32'd0);
            chk("mon_done_consec_s", 0, 32'(s_done & s_done_p), 32'd0);
        end
        d_done_p <= d_done;
        s_done_p <= s_done;
    end

    initial begin
        int sel, gap;
        bit hold;
        rst = 1'b1; start_d = 1'b0; start_s = 1'b0; clr_d = 1'b0; clr_s = 1'b0;
        in_base = '0; out_base = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_obs(0, sample(0), '0);
        chk_obs(0, sample(1), '0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle_cycles(1);

        run_job(0, 11'h010, 11'h100, 1'b0, 0);
        idle_cycles(1);
        run_job(0, 11'h7FD, 11'h7FF, 1'b0, 0);
        idle_cycles(2);

        run_job(0, 11'h020, 11'h200, 1'b1, 0);
        run_job(0, 11'h030, 11'h300, 1'b0, 0);
        idle_cycles(1);

        run_job(0, 11'h040, 11'h400, 1'b0, 14);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_obs(0, sample(0), '0);
        @(posedge clk); #1;
        chk_obs(0, sample(0), '0);
        rst = 1'b0;
        idle_cycles(3);

        run_job(1, 11'h055, 11'h066, 1'b0, 0);
        idle_cycles(1);
        run_job(1, 11'h7FF, 11'h000, 1'b1, 0);
        run_job(1, 11'h123, 11'h7FF, 1'b0, 0);
        idle_cycles(1);

        for (int i = 0; i < 12; i++) begin
            sel  = int'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            run_job(sel, 11'($urandom), 11'($urandom), hold, 0);
            if (hold) run_job(sel, 11'($urandom), 11'($urandom), 1'b0, 0);
            gap = int'($urandom_range(0, 3));
            idle_cycles(gap);
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
